// File: rtl/ibuff_reader_if.sv
// ---------------------------------------------------------------------------
// ibuff_reader_if
// Purpose : instruction handshake between the instruction-buffer reader and
//           decode.
// Signals : instr_out    - instruction word presented to decode
//           instr_valid  - instr_out holds a valid instruction
//           instr_ready  - decode accepts instr_out this cycle
//           instr_entry  - buffer entry the instruction came from
//           instr_offset - word index of the instruction inside its line
// Modports: master - the reader (drives instruction, samples ready)
//           slave  - decode (samples instruction, drives ready)
// ---------------------------------------------------------------------------
interface ibuff_reader_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int OFF_W       = 2
);
  logic [INSTR_WIDTH-1:0] instr_out;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [1:0]             instr_entry;
  logic [OFF_W-1:0]       instr_offset;

  modport master (
    output instr_out,
    output instr_valid,
    input  instr_ready,
    output instr_entry,
    output instr_offset
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    input  instr_entry,
    input  instr_offset
  );
endinterface

// File: rtl/ibuff_reader.sv
// ---------------------------------------------------------------------------
// ibuff_reader
// Purpose : read side of the frontend instruction buffer. Walks the four
//           cache-line entries in ring order, slices each valid line into
//           INSTR_WIDTH-bit instructions and presents one per cycle to decode.
//           Pulses a one-hot release when the last word of an entry is issued
//           so the fetch side can refill that entry.
// Ports   : clk          - sole clock, rising edge
//           rst          - synchronous active-high reset
//           line_data    - contents of buffer entries 0..3
//           line_valid   - per-entry valid bits
//           flush        - redirect pulse (drops in-flight instruction)
//           flush_entry  - entry to resume at after flush
//           flush_offset - word offset to resume at after flush
//           dec          - instruction handshake (ibuff_reader_if.master)
//           release_out  - one-hot, one-cycle "entry fully consumed" pulse
//                          ("release" itself is a reserved word in SV)
//           stall_count  - cycles with no valid instruction presented
// Options : define IBUFF_RD_PERF_EN to build the saturating stall counter;
//           otherwise stall_count is tied to zero.
// ---------------------------------------------------------------------------
module ibuff_reader #(
  parameter  int CACHE_LINE_SIZE = 128,
  parameter  int INSTR_WIDTH     = 32,
  localparam int WORDS           = CACHE_LINE_SIZE / INSTR_WIDTH,
  localparam int OFF_W           = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CACHE_LINE_SIZE-1:0] line_data [4],
  input  logic [3:0]                 line_valid,
  input  logic                       flush,
  input  logic [1:0]                 flush_entry,
  input  logic [OFF_W-1:0]           flush_offset,
  ibuff_reader_if.master             dec,
  output logic [3:0]                 release_out,
  output logic [31:0]                stall_count
);

  // Reader state: ISSUE whenever the entry under the read pointer is valid.
  localparam logic [0:0] ST_WAIT  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

  logic [1:0]             rd_ptr_q,       rd_ptr_d;
  logic [OFF_W-1:0]       rd_off_q,       rd_off_d;
  logic [INSTR_WIDTH-1:0] instr_out_q,    instr_out_d;
  logic [1:0]             instr_entry_q,  instr_entry_d;
  logic [OFF_W-1:0]       instr_offset_q, instr_offset_d;
  logic                   instr_valid_q,  instr_valid_d;
  logic [3:0]             release_q,      release_d;

  logic [0:0]             state;
  logic                   load;
  logic [CACHE_LINE_SIZE-1:0] cur_line;
  logic [INSTR_WIDTH-1:0] line_words [WORDS];
  logic [INSTR_WIDTH-1:0] cur_word;

  assign cur_line = line_data[rd_ptr_q];

  // Word 0 occupies the least significant bits of the line.
  for (genvar w = 0; w < WORDS; w++) begin : g_words
    assign line_words[w] = cur_line[w*INSTR_WIDTH +: INSTR_WIDTH];
  end

  assign cur_word = line_words[rd_off_q];

  // Decode the current state from the valid bit under the read pointer.
  always_comb begin
    if (line_valid[rd_ptr_q]) begin
      state = ST_ISSUE;
    end else begin
      state = ST_WAIT;
    end
  end

  // Load the output register when a word is available and the slot is free.
  always_comb begin
    load = 1'b0;
    case (state)
      ST_ISSUE: load = (!instr_valid_q || dec.instr_ready) && !flush;
      ST_WAIT:  load = 1'b0;
      default:  load = 1'b0;
    endcase
  end

  // Next-state logic for pointers, output register and release pulse.
  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    rd_off_d       = rd_off_q;
    instr_out_d    = instr_out_q;
    instr_entry_d  = instr_entry_q;
    instr_offset_d = instr_offset_q;
    instr_valid_d  = instr_valid_q;
    release_d      = 4'b0000;
    if (flush) begin
      // Redirect wins over everything; any same-cycle handshake is dropped
      // and the abandoned entry is left for the fetch side to invalidate.
      instr_valid_d = 1'b0;
      rd_ptr_d      = flush_entry;
      rd_off_d      = flush_offset;
    end else if (load) begin
      instr_out_d    = cur_word;
      instr_entry_d  = rd_ptr_q;
      instr_offset_d = rd_off_q;
      instr_valid_d  = 1'b1;
      if (rd_off_q == LAST_OFF) begin
        release_d = 4'b0001 << rd_ptr_q;
        rd_off_d  = '0;
        rd_ptr_d  = rd_ptr_q + 2'd1;
      end else begin
        rd_off_d  = rd_off_q + OFF_W'(1);
      end
    end else if (instr_valid_q && dec.instr_ready) begin
      instr_valid_d = 1'b0;
    end else begin
      instr_valid_d = instr_valid_q;
    end
  end

  // Reader state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q       <= 2'd0;
      rd_off_q       <= '0;
      instr_out_q    <= '0;
      instr_entry_q  <= 2'd0;
      instr_offset_q <= '0;
      instr_valid_q  <= 1'b0;
      release_q      <= 4'b0000;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      rd_off_q       <= rd_off_d;
      instr_out_q    <= instr_out_d;
      instr_entry_q  <= instr_entry_d;
      instr_offset_q <= instr_offset_d;
      instr_valid_q  <= instr_valid_d;
      release_q      <= release_d;
    end
  end

  assign dec.instr_out    = instr_out_q;
  assign dec.instr_valid  = instr_valid_q;
  assign dec.instr_entry  = instr_entry_q;
  assign dec.instr_offset = instr_offset_q;
  assign release_out      = release_q;

`ifdef IBUFF_RD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Count cycles in which decode sees no instruction, saturating at all-ones.
  always_comb begin
    if (!instr_valid_q && !flush && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_ibuff_reader.sv
// ---------------------------------------------------------------------------
// tb_ibuff_reader
// Directed bench for ibuff_reader: reset values, stall counter, single-line
// issue, four-line back-to-back issue with wrap, backpressure, flush and
// mid-line valid drop. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ibuff_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] line_data [4];
  logic [3:0]   line_valid;
  logic         flush;
  logic [1:0]   flush_entry;
  logic [1:0]   flush_offset;
  logic [3:0]   release_out;
  logic [31:0]  stall_count;

  int checks   = 0;
  int failures = 0;

  ibuff_reader_if #(.INSTR_WIDTH(32), .OFF_W(2)) dec_if ();

  ibuff_reader #(.CACHE_LINE_SIZE(128), .INSTR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_data    (line_data),
    .line_valid   (line_valid),
    .flush        (flush),
    .flush_entry  (flush_entry),
    .flush_offset (flush_offset),
    .dec          (dec_if),
    .release_out  (release_out),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instr(input string tag, input logic [31:0] e_out, input logic [1:0] e_ent,
                           input logic [1:0] e_off, input logic [3:0] e_rel);
    check({tag, ".valid"},  128'(dec_if.instr_valid),  128'(1'b1));
    check({tag, ".out"},    128'(dec_if.instr_out),    128'(e_out));
    check({tag, ".entry"},  128'(dec_if.instr_entry),  128'(e_ent));
    check({tag, ".offset"}, 128'(dec_if.instr_offset), 128'(e_off));
    check({tag, ".release"}, 128'(release_out),        128'(e_rel));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".valid"},   128'(dec_if.instr_valid), 128'(1'b0));
    check({tag, ".release"}, 128'(release_out),        128'(4'b0000));
  endtask

  function automatic logic [31:0] wv(input int k, input int w);
    return 32'hA000_0000 | 32'(k << 8) | 32'(w);
  endfunction

  initial begin
    logic [31:0] t1 [4];
    logic [31:0] held_out;
    t1 = '{32'hA, 32'hB, 32'hC, 32'hD};

    rst                = 1'b1;
    line_valid         = 4'b0000;
    flush              = 1'b0;
    flush_entry        = 2'd0;
    flush_offset       = 2'd0;
    dec_if.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) line_data[k] = 128'd0;

    // Reset values
    tick(); tick();
    chk_idle("reset");
    check("reset.out",    128'(dec_if.instr_out),    128'(32'd0));
    check("reset.entry",  128'(dec_if.instr_entry),  128'(2'd0));
    check("reset.offset", 128'(dec_if.instr_offset), 128'(2'd0));
    check("reset.stall",  128'(stall_count),         128'(32'd0));
    rst = 1'b0;

    // Ten starved cycles after reset
    repeat (10) tick();
`ifdef IBUFF_RD_PERF_EN
    check("stall10", 128'(stall_count), 128'(32'd10));
`else
    check("stall10", 128'(stall_count), 128'(32'd0));
`endif

    // Single line A,B,C,D then WAIT
    line_data[0] = {32'hD, 32'hC, 32'hB, 32'hA};
    line_valid   = 4'b0001;
    for (int w = 0; w < 4; w++) begin
      tick();
      chk_instr($sformatf("t1.w%0d", w), t1[w], 2'd0, 2'(w), (w == 3) ? 4'b0001 : 4'b0000);
    end
    line_valid = 4'b0000;
    tick();
    chk_idle("t1.wait");

    // Mid-operation reset, then four lines back to back
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 4; w++) line_data[k][w*32 +: 32] = wv(k, w);
    rst = 1'b1;
    tick();
    chk_idle("rst2");
    check("rst2.out", 128'(dec_if.instr_out), 128'(32'd0));
    rst        = 1'b0;
    line_valid = 4'b1111;
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 4; w++) begin
        tick();
        chk_instr($sformatf("t2.e%0dw%0d", k, w), wv(k, w), 2'(k), 2'(w),
                  (w == 3) ? (4'b0001 << k) : 4'b0000);
      end
    tick();
    chk_instr("t2.wrap", wv(0, 0), 2'd0, 2'd0, 4'b0000);
    line_valid = 4'b0000;
    tick();
    chk_idle("t2.wait");

    // Backpressure: entry 0 resumes at word 1
    line_valid = 4'b0001;
    tick();
    chk_instr("t3.w1", wv(0, 1), 2'd0, 2'd1, 4'b0000);
    held_out           = dec_if.instr_out;
    dec_if.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3.hold%0d.out", i), 128'(dec_if.instr_out), 128'(held_out));
      check($sformatf("t3.hold%0d.off", i), 128'(dec_if.instr_offset), 128'(2'd1));
      check($sformatf("t3.hold%0d.valid", i), 128'(dec_if.instr_valid), 128'(1'b1));
    end
    dec_if.instr_ready = 1'b1;
    tick();
    chk_instr("t3.w2", wv(0, 2), 2'd0, 2'd2, 4'b0000);
    tick();
    chk_instr("t3.w3", wv(0, 3), 2'd0, 2'd3, 4'b0001);
    line_valid = 4'b0000;
    tick();
    chk_idle("t3.wait");

    // Flush to entry 2 word 3 while a handshake is in progress
    line_valid = 4'b1111;
    tick();
    chk_instr("t4.e1w0", wv(1, 0), 2'd1, 2'd0, 4'b0000);
    flush        = 1'b1;
    flush_entry  = 2'd2;
    flush_offset = 2'd3;
    tick();
    chk_idle("t4.flush");
    flush = 1'b0;
    tick();
    chk_instr("t4.e2w3", wv(2, 3), 2'd2, 2'd3, 4'b0100);
    line_valid = 4'b0000;
    tick();
    chk_idle("t4.wait");

    // Line valid drops after word 1 of entry 3
    line_valid = 4'b1000;
    tick();
    chk_instr("t5.w0", wv(3, 0), 2'd3, 2'd0, 4'b0000);
    tick();
    chk_instr("t5.w1", wv(3, 1), 2'd3, 2'd1, 4'b0000);
    line_valid = 4'b0000;
    tick();
    chk_idle("t5.stall0");
    tick();
    chk_idle("t5.stall1");
    line_valid = 4'b1000;
    tick();
    chk_instr("t5.w2", wv(3, 2), 2'd3, 2'd2, 4'b0000);
    tick();
    chk_instr("t5.w3", wv(3, 3), 2'd3, 2'd3, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
